if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 25 ++
 rtl/inst_bus.sv | 22 ++
 rtl/if_pkt_reg.sv | 37 +++
 rtl/if_stage.sv | 120 ++++++++++++
 tb/tb_if_stage.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// default boot address and the packet handed to decode.
package if_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // no request outstanding
        WAIT = 2'd1,   // request outstanding, response will be used
        KILL = 2'd2,   // request outstanding, response will be dropped
        HALT = 2'd3    // fault delivered, fetching stopped until redirect
    } if_state_t;

    localparam logic [63:0] IF_RESET_PC = 64'h8000_0000;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        acc_err;
        logic        misalign;
    } if_pkt_t;

    function automatic logic is_aligned(input logic [63:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/inst_bus.sv
// Fetch port between the fetch stage (master) and the uncached
// instruction fetch unit (slave).
interface inst_bus;

    logic        en;
    logic [63:0] addr;
    logic        ready;
    logic        valid;
    logic [31:0] rdata;
    logic        acc_err;

    modport master (
        output en, addr, ready,
        input  valid, rdata, acc_err
    );

    modport slave (
        input  en, addr, ready,
        output valid, rdata, acc_err
    );

endinterface

// File: rtl/if_pkt_reg.sv
// One-entry valid/ready packet register between fetch and decode.
// Flush drops the held packet; contents stay stable while stalled.
module if_pkt_reg
    import if_stage_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    input  logic    flush,
    input  logic    load,
    input  if_pkt_t load_pkt,
    input  logic    out_ready,
    output logic    out_valid,
    output if_pkt_t out_pkt
);

    logic    vld_p1;
    if_pkt_t pkt_p1;

    // Flush beats load, load beats drain; data only changes on load.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            pkt_p1 <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (load) begin
            vld_p1 <= 1'b1;
            pkt_p1 <= load_pkt;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_pkt   = pkt_p1;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: keeps one fetch outstanding, turns responses
// into decode packets, handles redirects, access faults and misaligned PCs.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [63:0] RESET_PC = IF_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    inst_bus.master     ibus,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [63:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_acc_err,
    output logic        if_misalign
);

    if_state_t   state, state_nxt;
    logic [63:0] fetch_pc;
    logic [63:0] inflight_pc;
    logic [63:0] issue_addr;
    logic        issue_ok;
    logic        out_free;
    logic        resp_acc;
    logic        load_resp;
    logic        load_mis;
    logic        issue;
    if_pkt_t     pkt_in;
    if_pkt_t     pkt_out;

    assign issue_addr = redirect_valid ? redirect_pc : fetch_pc;
    assign issue_ok   = is_aligned(issue_addr);
    assign out_free   = !if_valid || if_ready;

    // A response is only taken when its packet can land (or will be dropped).
    assign ibus.ready = !reset && ((state == KILL) || redirect_valid || out_free);
    assign resp_acc   = ibus.valid && ibus.ready;

    assign load_resp  = (state == WAIT) && resp_acc && !redirect_valid;
    assign load_mis   = (state == IDLE) && !redirect_valid && !issue_ok && out_free;

    // A faulting response stops fetching, so it never chains a new request.
    assign issue = !reset && issue_ok &&
                   ((state == IDLE) ||
                    ((state == HALT) && redirect_valid) ||
                    (resp_acc && !(load_resp && ibus.acc_err)));

    assign ibus.en   = issue;
    assign ibus.addr = issue_addr;

    // Next state: a new request always means WAIT; redirect overrides the rest.
    always_comb begin
        state_nxt = state;
        if (issue) begin
            state_nxt = WAIT;
        end else if (redirect_valid) begin
            if (((state == WAIT) || (state == KILL)) && !resp_acc)
                state_nxt = KILL;
            else
                state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (load_mis) state_nxt = HALT;
                WAIT:    if (resp_acc) state_nxt = ibus.acc_err ? HALT : IDLE;
                KILL:    if (resp_acc) state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    // Packet contents: a misaligned PC or the response for the live request.
    always_comb begin
        pkt_in = '0;
        if (load_mis) begin
            pkt_in.pc       = issue_addr;
            pkt_in.misalign = 1'b1;
        end else begin
            pkt_in.pc      = inflight_pc;
            pkt_in.inst    = ibus.acc_err ? 32'h0 : ibus.rdata;
            pkt_in.acc_err = ibus.acc_err;
        end
    end

    // State and PC tracking; the next sequential PC wraps at 64 bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                inflight_pc <= issue_addr;
                fetch_pc    <= issue_addr + 64'd4;
            end else if (redirect_valid) begin
                fetch_pc <= redirect_pc;
            end
        end
    end

    if_pkt_reg u_pkt_reg (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect_valid),
        .load      (load_resp || load_mis),
        .load_pkt  (pkt_in),
        .out_ready (if_ready),
        .out_valid (if_valid),
        .out_pkt   (pkt_out)
    );

    assign if_pc       = pkt_out.pc;
    assign if_inst     = pkt_out.inst;
    assign if_acc_err  = pkt_out.acc_err;
    assign if_misalign = pkt_out.misalign;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a fetch-unit responder, a program-order packet model
// checked every cycle, and directed scenarios with literal expectations.
module tb_if_stage;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_inst;
    logic        if_acc_err;
    logic        if_misalign;

    inst_bus ibus ();

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clock          (clock),
        .reset          (reset),
        .ibus           (ibus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_acc_err     (if_acc_err),
        .if_misalign    (if_misalign)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Memory image seen through the fetch unit, and its fault region.
    function automatic logic [31:0] mem_word(input logic [63:0] pc);
        if (pc >= 64'h8000_0000 && pc < 64'h8000_0100) return 32'h0000_0013;
        return {pc[23:0], 8'h13};
    endfunction

    function automatic logic is_fault(input logic [63:0] pc);
        return pc[63:12] == 52'h1;
    endfunction

    // Responder and model state
    logic        busy = 1'b0, stale = 1'b0, nv = 1'b0;
    logic [63:0] q_addr = '0;
    int          cnt = 0, lat = 0;
    logic        pend = 1'b0, flush_chk = 1'b0, hold = 1'b0, rst_seen = 1'b0, halted = 1'b0;
    logic [63:0] exp_pc = RST_PC, pend_pc = '0, h_pc = '0;
    logic [31:0] h_inst = '0;
    logic [63:0] got_pc[$];
    logic [31:0] got_inst[$];
    logic        got_err[$];
    logic        got_mis[$];

    // Per-cycle compare against the program-order model, then advance it.
    always @(negedge clock) begin
        logic acc, mis, flt;
        if (reset) begin
            if (rst_seen) begin
                chk("reset_ibus_en", ibus.en, 0);
                chk("reset_ibus_ready", ibus.ready, 0);
                chk("reset_if_valid", if_valid, 0);
                chk("reset_if_pc", if_pc, 0);
                chk("reset_if_inst", if_inst, 0);
                chk("reset_if_acc_err", if_acc_err, 0);
                chk("reset_if_misalign", if_misalign, 0);
            end
            rst_seen = 1'b1;
            busy = 0; stale = 0; nv = 0; cnt = 0;
            pend = 0; flush_chk = 0; hold = 0; halted = 0;
            exp_pc = RST_PC;
        end else begin
            rst_seen = 1'b0;
            acc = ibus.valid && ibus.ready;
            if (pend) begin
                chk("resp_to_pkt_valid", if_valid, 1);
                chk("resp_to_pkt_pc", if_pc, pend_pc);
            end
            if (flush_chk) chk("dropped_resp_no_pkt", if_valid, 0);
            if (hold) begin
                chk("stall_valid_held", if_valid, 1);
                chk("stall_pc_held", if_pc, h_pc);
                chk("stall_inst_held", if_inst, h_inst);
            end
            if (ibus.en) begin
                chk("en_addr_aligned", ibus.addr[1:0], 0);
                chk("single_outstanding", busy && !acc, 0);
            end
            if (halted && !redirect_valid) chk("halted_no_en", ibus.en, 0);
            if (if_valid && if_ready && !redirect_valid) begin
                mis = exp_pc[1:0] != 2'b00;
                flt = !mis && is_fault(exp_pc);
                chk("pkt_while_halted", halted, 0);
                chk("pkt_pc", if_pc, exp_pc);
                chk("pkt_inst", if_inst, (mis || flt) ? 32'h0 : mem_word(exp_pc));
                chk("pkt_acc_err", if_acc_err, flt);
                chk("pkt_misalign", if_misalign, mis);
                got_pc.push_back(if_pc);
                got_inst.push_back(if_inst);
                got_err.push_back(if_acc_err);
                got_mis.push_back(if_misalign);
                exp_pc = exp_pc + 64'd4;
                if (mis || flt) halted = 1'b1;
            end
            pend      = acc && !redirect_valid && !stale;
            pend_pc   = q_addr;
            flush_chk = acc && (redirect_valid || stale);
            hold      = if_valid && !if_ready && !redirect_valid;
            h_pc      = if_pc;
            h_inst    = if_inst;
            if (redirect_valid) begin
                exp_pc = redirect_pc;
                halted = 1'b0;
            end
            if (acc) begin
                busy = 0; stale = 0;
            end else if (redirect_valid && busy) begin
                stale = 1;
            end
            if (ibus.en) begin
                busy = 1; stale = 0; q_addr = ibus.addr; cnt = lat;
            end else if (busy && cnt > 0) begin
                cnt--;
            end
            nv = busy && (cnt == 0);
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
        ibus.valid   = nv;
        ibus.acc_err = nv && is_fault(q_addr);
        ibus.rdata   = !nv ? 32'h0 : (is_fault(q_addr) ? 32'hDEAD_BEEF : mem_word(q_addr));
    endtask

    task automatic wait_pkt(input string name);
        int n0;
        n0 = got_pc.size();
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (got_pc.size() > n0) break;
        end
        chk(name, got_pc.size() > n0, 1);
    endtask

    task automatic wait_en(input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(); #1;
            if (ibus.en) begin found = 1'b1; break; end
        end
        chk(name, found, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] hpc;
        logic        found;
        int          n_en;
        reset = 1; redirect_valid = 0; redirect_pc = '0; if_ready = 1;
        ibus.valid = 0; ibus.rdata = '0; ibus.acc_err = 0;
        repeat (3) cyc();

        // Straight-line fetch from the boot address
        reset = 0; #1;
        chk("first_en", ibus.en, 1);
        chk("first_addr", ibus.addr, 64'h8000_0000);
        repeat (10) cyc();
        chk("seq_pc0", got_pc[0], 64'h8000_0000);
        chk("seq_pc1", got_pc[1], 64'h8000_0004);
        chk("seq_pc2", got_pc[2], 64'h8000_0008);
        chk("seq_inst0", got_inst[0], 32'h0000_0013);

        // Decode stalls for five cycles
        if_ready = 0; #1;
        chk("stall_start_valid", if_valid, 1);
        hpc = if_pc;
        for (int i = 0; i < 5; i++) begin
            chk("stall_ibus_ready", ibus.ready, 0);
            chk("stall_no_en", ibus.en, 0);
            chk("stall_pc_stable", if_pc, hpc);
            cyc(); #1;
        end
        if_ready = 1;
        repeat (3) cyc();

        // Redirect while a request is outstanding with no response yet
        lat = 3;
        wait_en("wait_en_seen");
        cyc();
        redirect_valid = 1; redirect_pc = 64'h8000_0100; #1;
        chk("redir_wait_no_en", ibus.en, 0);
        chk("redir_wait_no_resp", ibus.valid, 0);
        lat = 0;
        cyc(); redirect_valid = 0;
        wait_pkt("redir_wait_pkt");
        chk("redir_wait_pc", got_pc[$], 64'h8000_0100);
        chk("redir_wait_inst", got_inst[$], 32'h0001_0013);

        // Redirect in the same cycle a response is accepted
        repeat (4) cyc();
        found = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (ibus.valid) begin found = 1; break; end
        end
        chk("resp_seen", found, 1);
        redirect_valid = 1; redirect_pc = 64'h8000_0200; #1;
        chk("redir_acc_taken", ibus.valid && ibus.ready, 1);
        chk("redir_acc_en", ibus.en, 1);
        chk("redir_acc_addr", ibus.addr, 64'h8000_0200);
        cyc(); redirect_valid = 0;
        wait_pkt("redir_acc_pkt");
        chk("redir_acc_pc", got_pc[$], 64'h8000_0200);
        chk("redir_acc_inst", got_inst[$], 32'h0002_0013);

        // Access fault at 0x1000 stops fetching
        cyc(); redirect_valid = 1; redirect_pc = 64'h1000;
        cyc(); redirect_valid = 0;
        wait_pkt("fault_pkt");
        chk("fault_pc", got_pc[$], 64'h1000);
        chk("fault_inst", got_inst[$], 0);
        chk("fault_acc_err", got_err[$], 1);
        chk("fault_misalign", got_mis[$], 0);
        n_en = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(); #1;
            if (ibus.en) n_en++;
        end
        chk("fault_no_en", n_en, 0);
        chk("fault_if_valid_low", if_valid, 0);

        // Misaligned redirect target
        redirect_valid = 1; redirect_pc = 64'h8000_0002; #1;
        chk("mis_redir_no_en", ibus.en, 0);
        cyc(); redirect_valid = 0;
        wait_pkt("mis_pkt");
        chk("mis_pc", got_pc[$], 64'h8000_0002);
        chk("mis_flag", got_mis[$], 1);
        chk("mis_inst", got_inst[$], 0);
        chk("mis_acc_err", got_err[$], 0);
        n_en = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(); #1;
            if (ibus.en) n_en++;
        end
        chk("mis_no_en", n_en, 0);
        redirect_valid = 1; redirect_pc = 64'h8000_0010;
        cyc(); redirect_valid = 0;
        wait_pkt("halt_exit_pkt");
        chk("halt_exit_pc", got_pc[$], 64'h8000_0010);
        chk("halt_exit_inst", got_inst[$], 32'h0000_0013);

        // Sequential PC wraps at 64 bits
        repeat (3) cyc();
        redirect_valid = 1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc(); redirect_valid = 0;
        wait_pkt("wrap_pkt0");
        chk("wrap_pc0", got_pc[$], 64'hFFFF_FFFF_FFFF_FFFC);
        wait_pkt("wrap_pkt1");
        chk("wrap_pc1", got_pc[$], 64'h0);
        chk("wrap_inst1", got_inst[$], 32'h0000_0013);

        // Reset with a request outstanding
        lat = 3;
        wait_en("pre_reset_en_seen");
        cyc(); reset = 1; lat = 0;
        repeat (3) cyc();
        reset = 0;
        wait_pkt("post_reset_pkt");
        chk("post_reset_pc", got_pc[$], 64'h8000_0000);
        chk("post_reset_inst", got_inst[$], 32'h0000_0013);
        repeat (3) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
